// File: rtl/m2vdd_hx8347a_rx.sv
// HX8347-A 8080 write-bus responder: decodes window/cursor writes and streams GRAM pixels
// to an Avalon-MM master. Optional macro M2VDD_RX_RGB888_EN widens pixel data to 32-bit RGB888.
module m2vdd_hx8347a_rx #(
    parameter int H_PIXELS   = 240,
    parameter int V_PIXELS   = 320,
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  lcd_reset_n,
    input  logic                  lcd_cs,
    input  logic                  lcd_rs,
    input  logic [15:0]           lcd_data,
    input  logic                  lcd_write_n,
    output logic [ADDR_WIDTH-1:0] pix_address,
    output logic                  pix_write,
`ifdef M2VDD_RX_RGB888_EN
    output logic [31:0]           pix_writedata,
`else
    output logic [15:0]           pix_writedata,
`endif
    input  logic                  pix_waitrequest,
    input  logic                  ovf_clear,
    output logic                  overflow,
    output logic                  frame_done
);

    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam logic [8:0] EC_RST = 9'(H_PIXELS - 1);
    localparam logic [8:0] EP_RST = 9'(V_PIXELS - 1);
    localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0] CNT_ONE  = (FIFO_LOG2 + 1)'(1);

    typedef enum logic [0:0] {ST_IDLE, ST_WRITE} state_t;

    // Two-deep bus sampling: the older stage holds the values seen while the strobe was low
    logic        cs_s_reg, rs_s_reg, wr_n_s_reg;
    logic [15:0] data_s_reg;
    logic        cs_d_reg, rs_d_reg, wr_n_d_reg;
    logic [15:0] data_d_reg;
    logic        lcd_rst_n_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_s_reg      <= 1'b1;
            rs_s_reg      <= 1'b0;
            wr_n_s_reg    <= 1'b1;
            data_s_reg    <= '0;
            cs_d_reg      <= 1'b1;
            rs_d_reg      <= 1'b0;
            wr_n_d_reg    <= 1'b1;
            data_d_reg    <= '0;
            lcd_rst_n_reg <= 1'b1;
        end else begin
            cs_s_reg      <= lcd_cs;
            rs_s_reg      <= lcd_rs;
            wr_n_s_reg    <= lcd_write_n;
            data_s_reg    <= lcd_data;
            cs_d_reg      <= cs_s_reg;
            rs_d_reg      <= rs_s_reg;
            wr_n_d_reg    <= wr_n_s_reg;
            data_d_reg    <= data_s_reg;
            lcd_rst_n_reg <= lcd_reset_n;
        end
    end

    logic commit, idx_wr, dat_wr, pix_wr;
    assign commit = !wr_n_d_reg && wr_n_s_reg && !cs_d_reg && lcd_rst_n_reg;
    assign idx_wr = commit && !rs_d_reg;
    assign dat_wr = commit && rs_d_reg;

    logic [7:0] index_reg;
    logic [8:0] sc_reg, ec_reg, sp_reg, ep_reg, col_reg, row_reg;
    logic       frame_done_reg;
    logic       col_at_end, row_at_end;

    assign pix_wr     = dat_wr && (index_reg == 8'h22);
    assign col_at_end = (col_reg == ec_reg);
    assign row_at_end = (row_reg == ep_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_reg      <= '0;
            sc_reg         <= '0;
            ec_reg         <= EC_RST;
            sp_reg         <= '0;
            ep_reg         <= EP_RST;
            col_reg        <= '0;
            row_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else if (!lcd_rst_n_reg) begin
            index_reg      <= '0;
            sc_reg         <= '0;
            ec_reg         <= EC_RST;
            sp_reg         <= '0;
            ep_reg         <= EP_RST;
            col_reg        <= '0;
            row_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= pix_wr && col_at_end && row_at_end;
            if (idx_wr) begin
                index_reg <= data_d_reg[7:0];
                if (data_d_reg[7:0] == 8'h22) begin
                    col_reg <= sc_reg;
                    row_reg <= sp_reg;
                end
            end else if (dat_wr) begin
                case (index_reg)
                    8'h02: sc_reg[8]   <= data_d_reg[0];
                    8'h03: sc_reg[7:0] <= data_d_reg[7:0];
                    8'h04: ec_reg[8]   <= data_d_reg[0];
                    8'h05: ec_reg[7:0] <= data_d_reg[7:0];
                    8'h06: sp_reg[8]   <= data_d_reg[0];
                    8'h07: sp_reg[7:0] <= data_d_reg[7:0];
                    8'h08: ep_reg[8]   <= data_d_reg[0];
                    8'h09: ep_reg[7:0] <= data_d_reg[7:0];
                    8'h22: begin
                        // Cursor advances even when the pixel itself is dropped
                        if (!col_at_end) begin
                            col_reg <= col_reg + 9'd1;
                        end else begin
                            col_reg <= sc_reg;
                            row_reg <= row_at_end ? sp_reg : row_reg + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [ADDR_WIDTH-1:0] push_addr;
    assign push_addr = ADDR_WIDTH'(row_reg) * ADDR_WIDTH'(H_PIXELS) + ADDR_WIDTH'(col_reg);

    // FIFO entry stays resident until the Avalon slave accepts it
    logic [ADDR_WIDTH+15:0] fifo_mem [DEPTH];
    logic [FIFO_LOG2:0]     wr_ptr_reg, rd_ptr_reg, fifo_count;
    logic                   fifo_full, fifo_release, push_ok, drop;
    logic                   load_en, load_sel_next, write_end;
    logic [FIFO_LOG2-1:0]   rd_idx;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign push_ok    = pix_wr && (!fifo_full || fifo_release);
    assign drop       = pix_wr && fifo_full && !fifo_release;
    assign rd_idx     = rd_ptr_reg[FIFO_LOG2-1:0] + FIFO_LOG2'(load_sel_next);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[FIFO_LOG2-1:0]] <= {push_addr, data_d_reg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (!lcd_rst_n_reg) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + CNT_ONE;
            if (fifo_release) rd_ptr_reg <= rd_ptr_reg + CNT_ONE;
        end
    end

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else if (!lcd_rst_n_reg) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fifo_count != '0) state_next = ST_WRITE;
            ST_WRITE: if (!pix_waitrequest && fifo_count <= CNT_ONE) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_release  = 1'b0;
        load_en       = 1'b0;
        load_sel_next = 1'b0;
        write_end     = 1'b0;
        case (state_reg)
            ST_IDLE: load_en = (fifo_count != '0);
            ST_WRITE: begin
                if (!pix_waitrequest) begin
                    fifo_release = 1'b1;
                    if (fifo_count > CNT_ONE) begin
                        load_en       = 1'b1;
                        load_sel_next = 1'b1;
                    end else begin
                        write_end = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    logic [ADDR_WIDTH-1:0] pix_address_reg;
    logic [15:0]           pix_data_reg;
    logic                  pix_write_reg, overflow_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_address_reg <= '0;
            pix_data_reg    <= '0;
            pix_write_reg   <= 1'b0;
        end else if (!lcd_rst_n_reg) begin
            pix_address_reg <= '0;
            pix_data_reg    <= '0;
            pix_write_reg   <= 1'b0;
        end else if (load_en) begin
            {pix_address_reg, pix_data_reg} <= fifo_mem[rd_idx];
            pix_write_reg <= 1'b1;
        end else if (write_end) begin
            pix_write_reg <= 1'b0;
        end
    end

    // A fresh drop beats a simultaneous clear; panel soft reset leaves the flag alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (ovf_clear) begin
            overflow_reg <= 1'b0;
        end
    end

    assign pix_address = pix_address_reg;
    assign pix_write   = pix_write_reg;
    assign overflow    = overflow_reg;
    assign frame_done  = frame_done_reg;

`ifdef M2VDD_RX_RGB888_EN
    assign pix_writedata = {8'h00,
                            pix_data_reg[15:11], pix_data_reg[15:13],
                            pix_data_reg[10:5],  pix_data_reg[10:9],
                            pix_data_reg[4:0],   pix_data_reg[4:2]};
`else
    assign pix_writedata = pix_data_reg;
`endif

endmodule

// File: tb/tb_m2vdd_hx8347a_rx.sv
// Bench for m2vdd_hx8347a_rx: directed + randomized bus traffic checked against a queue-based panel model.
module tb_m2vdd_hx8347a_rx;

`ifdef M2VDD_RX_RGB888_EN
    localparam int PIX_DW = 32;
`else
    localparam int PIX_DW = 16;
`endif

    logic              clk = 1'b0;
    logic              reset_n, lcd_reset_n, lcd_cs, lcd_rs, lcd_write_n;
    logic [15:0]       lcd_data;
    logic [16:0]       pix_address;
    logic              pix_write, pix_waitrequest, ovf_clear, overflow, frame_done;
    logic [PIX_DW-1:0] pix_writedata;

    always #5 clk = ~clk;

    m2vdd_hx8347a_rx dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .lcd_reset_n    (lcd_reset_n),
        .lcd_cs         (lcd_cs),
        .lcd_rs         (lcd_rs),
        .lcd_data       (lcd_data),
        .lcd_write_n    (lcd_write_n),
        .pix_address    (pix_address),
        .pix_write      (pix_write),
        .pix_writedata  (pix_writedata),
        .pix_waitrequest(pix_waitrequest),
        .ovf_clear      (ovf_clear),
        .overflow       (overflow),
        .frame_done     (frame_done)
    );

    typedef struct packed {
        logic [16:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   fd_count = 0;
    int   wr_count = 0;
    int   m_idx, m_sc, m_ec, m_sp, m_ep, m_col, m_row, m_frames;
    bit   m_hold = 1'b0;
    bit   rand_wait = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [15:0] d);
`ifdef M2VDD_RX_RGB888_EN
        int r, g, b;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        return 32'((((r * 8) + (r / 4)) * 65536) + (((g * 4) + (g / 16)) * 256) + (b * 8) + (b / 4));
`else
        return {16'h0000, d};
`endif
    endfunction

    task automatic model_reset();
        m_idx = 0; m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319; m_col = 0; m_row = 0;
    endtask

    // Panel behaviour in plain integer arithmetic: window registers, raster cursor, FIFO capacity
    task automatic model_write(input logic rs, input logic [15:0] d);
        exp_t e;
        if (!rs) begin
            m_idx = int'(d[7:0]);
            if (m_idx == 'h22) begin
                m_col = m_sc;
                m_row = m_sp;
            end
        end else begin
            case (m_idx)
                'h02: m_sc = (m_sc % 256) + 256 * int'(d[0]);
                'h03: m_sc = (m_sc / 256) * 256 + int'(d[7:0]);
                'h04: m_ec = (m_ec % 256) + 256 * int'(d[0]);
                'h05: m_ec = (m_ec / 256) * 256 + int'(d[7:0]);
                'h06: m_sp = (m_sp % 256) + 256 * int'(d[0]);
                'h07: m_sp = (m_sp / 256) * 256 + int'(d[7:0]);
                'h08: m_ep = (m_ep % 256) + 256 * int'(d[0]);
                'h09: m_ep = (m_ep / 256) * 256 + int'(d[7:0]);
                'h22: begin
                    if (!(m_hold && exp_q.size() >= 16)) begin
                        e.addr = 17'((m_row * 240 + m_col) % 131072);
                        e.data = exp_data(d);
                        exp_q.push_back(e);
                    end
                    if (m_col != m_ec) begin
                        m_col = (m_col + 1) % 512;
                    end else begin
                        m_col = m_sc;
                        if (m_row == m_ep) begin
                            m_row = m_sp;
                            m_frames++;
                        end else begin
                            m_row = (m_row + 1) % 512;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic bus_write(input logic cs, input logic rs, input logic [15:0] d);
        lcd_cs = cs; lcd_rs = rs; lcd_data = d; lcd_write_n = 1'b0;
        if (rand_wait) pix_waitrequest = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        lcd_write_n = 1'b1;
        if (rand_wait) pix_waitrequest = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        lcd_cs = 1'b0;
        if (!cs) model_write(rs, d);
    endtask

    task automatic set_window(input int sc, input int ec, input int sp, input int ep);
        bus_write(1'b0, 1'b0, 16'h02); bus_write(1'b0, 1'b1, 16'(sc / 256));
        bus_write(1'b0, 1'b0, 16'h03); bus_write(1'b0, 1'b1, 16'(sc % 256));
        bus_write(1'b0, 1'b0, 16'h04); bus_write(1'b0, 1'b1, 16'(ec / 256));
        bus_write(1'b0, 1'b0, 16'h05); bus_write(1'b0, 1'b1, 16'(ec % 256));
        bus_write(1'b0, 1'b0, 16'h06); bus_write(1'b0, 1'b1, 16'(sp / 256));
        bus_write(1'b0, 1'b0, 16'h07); bus_write(1'b0, 1'b1, 16'(sp % 256));
        bus_write(1'b0, 1'b0, 16'h08); bus_write(1'b0, 1'b1, 16'(ep / 256));
        bus_write(1'b0, 1'b0, 16'h09); bus_write(1'b0, 1'b1, 16'(ep % 256));
        bus_write(1'b0, 1'b0, 16'h22);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pix_write) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frames"}, 32'(fd_count), 32'(m_frames));
    endtask

    // Accepted-write and frame pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (frame_done) fd_count++;
            if (pix_write && !pix_waitrequest) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {15'd0, pix_address}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_address", {15'd0, pix_address}, {15'd0, e.addr});
                    check("pix_writedata", 32'(pix_writedata), e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before, np;
        reset_n = 1'b0; lcd_reset_n = 1'b1; lcd_cs = 1'b0; lcd_rs = 1'b0;
        lcd_data = '0; lcd_write_n = 1'b1; pix_waitrequest = 1'b0; ovf_clear = 1'b0;
        m_frames = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_pix_write", 32'(pix_write), 32'd0);
        check("rst_pix_address", {15'd0, pix_address}, 32'd0);
        check("rst_pix_writedata", 32'(pix_writedata), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // 16x16 window, full frame
        set_window(16, 31, 32, 47);
        for (int i = 0; i < 256; i++) bus_write(1'b0, 1'b1, 16'($urandom));
        wait_drain("win16");

        // 2x1 window wraps every two pixels
        set_window(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) bus_write(1'b0, 1'b1, 16'($urandom));
        wait_drain("win2");

        // Deselected strobes must be ignored entirely
        wr_before = wr_count;
        bus_write(1'b1, 1'b0, 16'h22);
        bus_write(1'b1, 1'b1, 16'h1234);
        bus_write(1'b1, 1'b1, 16'h5678);
        repeat (6) @(posedge clk);
        #1;
        check("cs_high_no_write", 32'(wr_count), 32'(wr_before));
        bus_write(1'b0, 1'b1, 16'hABCD);
        wait_drain("cs_high");

        // Random windows with random back-pressure
        for (int r = 0; r < 3; r++) begin
            int sc, sp;
            sc = int'($urandom_range(0, 230));
            sp = int'($urandom_range(0, 300));
            set_window(sc, sc + int'($urandom_range(0, 5)), sp, sp + int'($urandom_range(0, 3)));
            rand_wait = 1'b1;
            np = int'($urandom_range(5, 40));
            for (int i = 0; i < np; i++) bus_write(1'b0, 1'b1, 16'($urandom));
            rand_wait = 1'b0;
            pix_waitrequest = 1'b0;
            wait_drain("random");
        end

        // Stall the slave long enough to overflow the FIFO
        pix_waitrequest = 1'b1;
        m_hold = 1'b1;
        set_window(0, 239, 0, 319);
        wr_before = wr_count;
        for (int i = 0; i < 20; i++) bus_write(1'b0, 1'b1, 16'($urandom));
        repeat (4) @(posedge clk);
        #1;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_no_accept", 32'(wr_count), 32'(wr_before));
        pix_waitrequest = 1'b0;
        m_hold = 1'b0;
        wait_drain("ovf");
        check("ovf_write_count", 32'(wr_count - wr_before), 32'd16);

        // Panel soft reset mid-burst abandons the queued words but keeps overflow
        pix_waitrequest = 1'b1;
        m_hold = 1'b1;
        bus_write(1'b0, 1'b0, 16'h22);
        for (int i = 0; i < 4; i++) bus_write(1'b0, 1'b1, 16'($urandom));
        repeat (3) @(posedge clk);
        #1;
        check("srst_write_pending", 32'(pix_write), 32'd1);
        lcd_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("srst_pix_write_drop", 32'(pix_write), 32'd0);
        exp_q.delete();
        model_reset();
        m_hold = 1'b0;
        wr_before = wr_count;
        pix_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1 lcd_reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("srst_fifo_empty", 32'(wr_count), 32'(wr_before));
        check("srst_ovf_kept", 32'(overflow), 32'd1);
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Default window after soft reset: 241 pixels wrap at column 239
        bus_write(1'b0, 1'b0, 16'h22);
        for (int i = 0; i < 241; i++) bus_write(1'b0, 1'b1, 16'($urandom));
        wait_drain("post_srst");

        // Colour corner values
        bus_write(1'b0, 1'b1, 16'h001F);
        bus_write(1'b0, 1'b1, 16'h8410);
        bus_write(1'b0, 1'b1, 16'hF800);
        bus_write(1'b0, 1'b1, 16'h07E0);
        wait_drain("colour");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m2vdd_hx8347a_rx.md
Name: m2vdd_hx8347a_rx

Overview:
- Bus-responder model of the HX8347-A panel: receives the 8080-style write bus produced by the display driver and decodes index and data writes.
- Keeps the column/row window registers and an auto-incrementing cursor, and converts GRAM data writes into linear frame-buffer writes on an Avalon-MM master.
- Used in the loopback test system to mirror the LCD image into SDRAM for checking. All bus inputs are synchronous to clk.

Parameters:
H_PIXELS, 240, panel columns; sets the linear address stride
V_PIXELS, 320, panel rows; cursor row range
ADDR_WIDTH, 17, pixel address width (covers 240*320 = 76800)
FIFO_LOG2, 4, pending-pixel FIFO depth = 2**FIFO_LOG2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
lcd_reset_n  in  1  panel reset from bus; low = synchronous soft reset
lcd_cs  in  1  chip select, active low
lcd_rs  in  1  0 = index write, 1 = data write
lcd_data  in  16  bus data
lcd_write_n  in  1  write strobe, active low
pix_address  out  ADDR_WIDTH  Avalon-MM master address (pixel units)
pix_write  out  1  Avalon-MM write request
pix_writedata  out  16 (32 with feature)  pixel data
pix_waitrequest  in  1  Avalon-MM wait request
ovf_clear  in  1  clears the sticky overflow flag
overflow  out  1  sticky; a pixel was dropped because the FIFO was full
frame_done  out  1  one-cycle pulse when the cursor wraps past (EC,EP)

Behaviour:
Reset values:
- pix_write 0, pix_address 0, pix_writedata 0, overflow 0, frame_done 0.
- Index register 0; SC 0; EC H_PIXELS-1; SP 0; EP V_PIXELS-1; cursor (0,0); FIFO empty.

Input stage:
- lcd_cs, lcd_rs, lcd_data and lcd_write_n are registered once.
- A write is committed in the cycle where the registered strobe goes 0->1 (previous 0, current 1), using the rs/data registered while the strobe was low.
- Required strobe timing: low ≥1 clk, high ≥1 clk.
- The strobe is ignored if cs was high during the low phase.
- Write latency: 2 clk from the bus rising edge to the decoder action.

Decoder:
- Index write (rs=0): index <= data[7:0].
- Data write (rs=1), by index:
  - 0x02: SC[8] <= data[0]
  - 0x03: SC[7:0] <= data[7:0]
  - 0x04: EC[8] <= data[0]
  - 0x05: EC[7:0] <= data[7:0]
  - 0x06: SP[8] <= data[0]
  - 0x07: SP[7:0] <= data[7:0]
  - 0x08: EP[8] <= data[0]
  - 0x09: EP[7:0] <= data[7:0]
  - 0x22: GRAM pixel (see below)
  - any other index: ignored.
- Index write of 0x22 loads the cursor: col <= SC, row <= SP.

GRAM pixel write:
- Enqueue {row*H_PIXELS + col, data}; the multiply is by constant, truncated to ADDR_WIDTH.
- Cursor advance:
  - col != EC: col+1.
  - col == EC: col <= SC and row advances.
  - row == EP on that wrap: row <= SP, frame_done pulses the next cycle.
- Window values are used as written; no range clamping. SC>EC runs up to 511 and wraps in 9 bits.

FIFO full:
- The pixel is dropped and overflow is set, but the cursor still advances.
- If ovf_clear and a new overflow occur in the same cycle, the new overflow wins (flag stays 1).

Output FSM, states ST_IDLE and ST_WRITE:
- ST_IDLE: if the FIFO is non-empty, pop the head into pix_address/pix_writedata, assert pix_write, go to ST_WRITE.
- ST_WRITE: hold address and data while pix_waitrequest=1.
  - On accept, pop the next entry if one is present and stay in ST_WRITE (back-to-back, 1 word/clk sustained).
  - Otherwise deassert pix_write and go to ST_IDLE.
- A simultaneous enqueue and dequeue while the FIFO is full is allowed; the write is not dropped.

lcd_reset_n low (registered):
- Returns all registers, cursor and the FIFO to reset values and aborts the output FSM to ST_IDLE.
- An outstanding Avalon write is abandoned; pix_write drops the next cycle.
- overflow is kept.

Optional Feature:
- Macro M2VDD_RX_RGB888_EN.
- Defined: pix_writedata is 32 bits = {8'h00, R5 expanded to 8 bits by MSB replication, G6 expanded likewise, B5 expanded likewise}. Example: 16'hF800 -> 32'h00FF0000; 16'h07E0 -> 32'h0000FF00.
- Undefined: pix_writedata is 16 bits, the raw RGB565 word.

Test Plan:
- Write sequence: idx 0x03, data 0x10; idx 0x05, data 0x1F; idx 0x07, data 0x20; idx 0x09, data 0x2F; idx 0x22; 256 data words -> 256 writes at addresses 32*240+16 through 47*240+31, row-major, data in order, frame_done pulses once after the 256th.
- Window col 0..1, row 0..0; 5 pixels -> addresses 0,1,0,1,0; frame_done after the 2nd and 4th pixels.
- pix_waitrequest held high for 40 clk while 20 pixels arrive at 1 per 2 clk, FIFO_LOG2=4 -> exactly 4 pixels dropped, overflow=1, 16 writes after release in order; ovf_clear -> overflow=0.
- Strobes with lcd_cs=1 and index 0x22 -> no pix_write and cursor unchanged.
- lcd_reset_n pulsed low mid-burst with 3 words queued -> pix_write=0 within 2 clk, FIFO empty, EC reads back as 239 (next pixel after idx 0x22 lands at address 0).
- With M2VDD_RX_RGB888_EN: data 16'h001F -> pix_writedata 32'h000000FF; 16'h8410 -> 32'h00848284.
